mem_bus_responder: RTL and testbench
====================================

# mem_bus_responder

Memory-side responder for the processor's single-master MR/MW memory bus. It accepts read and write requests from the control state machine and inserts a parameterised number of wait states. It holds BUSY high until the access completes, then signals completion with a one-cycle BUSY-low / ACK_N-low strobe. It sits between the datapath's address/data lines and a word-addressed storage array, and is the bus counterpart of the processor control FSM.

## Interface
Parameters:
- ADDR_W, 5, word-address width; the array depth is 2^ADDR_W words.
- DATA_W, 32, data word width.
- WAIT_CYCLES, 2, wait states inserted before completion; legal range 0..15.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- MR  in  1  read request; level, held by the initiator until completion.
- MW  in  1  write request; level, held by the initiator until completion.
- ADDR  in  ADDR_W  word address; sampled when a request is accepted.
- DIN  in  DATA_W  write data; sampled when a request is accepted.
- DOUT  out  DATA_W  registered read data.
- BUSY  out  1  combinational; high while a request is pending and not yet completed.
- ACK_N  out  1  active-low completion strobe, one cycle wide.
- ERR  out  1  sticky protocol-error flag.
- RSP_STATE  out  2  current FSM state, for debug and the step display.

## Operation
- States: IDLE=0, WAIT=1, DONE=2. Encoding 3 is illegal and returns to IDLE.
- IDLE:
  - When MR|MW is high, latch ADDR, DIN and the operation (read if MR=1).
  - Load the wait counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to DONE.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==1 at an edge, go to DONE.
  - If MR|MW drops while in WAIT, abort: return to IDLE, commit no write, leave DOUT unchanged.
- Commit happens on the edge that enters DONE:
  - Read: DOUT <= mem[latched addr].
  - Write: mem[latched addr] <= latched data. DOUT is unchanged.
- DONE: go to IDLE unconditionally. A request seen in the following IDLE cycle is a new request.
- BUSY = RESET_N & (MR|MW) & (state!=DONE). It is combinational so the initiator sees BUSY=1 in the same cycle it raises MR/MW.
- ACK_N = 0 exactly when state==DONE.
- MR and MW both high at acceptance:
  - Perform a read; MW is ignored.
  - Set ERR; it stays set until reset.
- ADDR and DIN changes after acceptance are ignored.
- The storage array is not reset. Its contents are undefined until written.

## Timing
- Reset values: state=IDLE, DOUT=0, ACK_N=1, ERR=0, RSP_STATE=0, counter=0. BUSY=0 while RESET_N is low.
- Reset asserted mid-access abandons the access immediately: no write is committed and DOUT becomes 0.
- Latency: a request first visible at cycle 0 produces DONE (BUSY=0, ACK_N=0, DOUT valid) at cycle WAIT_CYCLES+1.
  - The initiator samples BUSY=0 at the end of that cycle.
  - With WAIT_CYCLES=0, DONE occurs at cycle 1.
- Minimum gap between completions is WAIT_CYCLES+2 cycles: IDLE, then WAIT cycles, then DONE.
- A read's DOUT stays stable from DONE until the next read commit or reset.

## Structure
- Shared package `mem_bus_pkg` holds:
  - the state encodings (IDLE/WAIT/DONE);
  - the default ADDR_W, DATA_W and WAIT_CYCLES values;
  - the opcode constants used by the control FSM (LW=6'b100011, SW=6'b101011).
- Sub-module `mem_bus_sram_array`: a synchronous single-port word array (write enable, address, din, registered dout) with no reset. The FSM, counter, latches and ERR live in the top module.

## Test plan
- Read with WAIT_CYCLES=2, mem[5] preloaded to 0xDEADBEEF: MR=1, ADDR=5 at cycle 0 → BUSY=1 at cycles 0–2; at cycle 3 BUSY=0, ACK_N=0, DOUT=0xDEADBEEF; cycle 4 back in IDLE.
- Write then read: MW=1, ADDR=7, DIN=0x12345678 until BUSY=0, then MR=1, ADDR=7 → DOUT=0x12345678. DOUT is unchanged after the write phase.
- WAIT_CYCLES=0 build: MR at cycle 0 → ACK_N=0, DOUT valid at cycle 1; back-to-back requests separated by one IDLE cycle are each served.
- Abort: MW=1, ADDR=3, DIN=0xAAAA0000, dropped at cycle 1 with WAIT_CYCLES=2 → no ACK_N pulse, RSP_STATE=0 at cycle 2, and a subsequent read of mem[3] returns the prior value.
- Protocol error: MR=MW=1, ADDR=2 → read of mem[2] completes normally, ERR=1 and stays 1 across later legal accesses until RESET_N pulses low.
- Reset mid-WAIT: RESET_N low at cycle 1 of a write → BUSY=0, ACK_N=1, DOUT=0, state IDLE immediately, and the target word is unmodified.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the MR/MW memory bus: responder state encodings,
// default geometry/timing, and the load/store opcodes used by the control FSM.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } rsp_state_t;

    localparam int unsigned DEF_ADDR_W      = 5;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_WAIT_CYCLES = 2;

    // Wide enough for the full 0..15 wait-state range.
    localparam int unsigned CNT_W = 4;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    function automatic logic is_mem_op(input logic [5:0] opcode);
        return (opcode == OP_LW) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/mem_bus_sram_array.sv
// Synchronous single-port word array with a registered, read-enabled output.
// Neither the storage nor the output register is reset.
module mem_bus_sram_array #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        if (re) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the MR/MW bus: accepts a request, inserts
// WAIT_CYCLES wait states, commits to the word array and strobes ACK_N.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              MR,
    input  logic              MW,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic              BUSY,
    output logic              ACK_N,
    output logic              ERR,
    output logic [1:0]        RSP_STATE
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               ZERO_WAIT = (WAIT_CYCLES == 0);

    rsp_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              rd_q;
    logic              ack_n_q;
    logic              err_q;
    logic              dout_vld;

    logic              req;
    logic              commit;
    logic              commit_rd;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_din;
    logic [DATA_W-1:0] sram_q;

    assign req = MR | MW;

    // A zero-wait build commits straight from IDLE, so the live bus values
    // are used because the latches only capture them on that same edge.
    always_comb begin
        commit      = 1'b0;
        commit_rd   = rd_q;
        commit_addr = addr_q;
        commit_din  = din_q;
        case (state)
            ST_IDLE: begin
                if (ZERO_WAIT && req) begin
                    commit      = 1'b1;
                    commit_rd   = MR;
                    commit_addr = ADDR;
                    commit_din  = DIN;
                end
            end
            ST_WAIT: begin
                if (req && (cnt == CNT_ONE)) begin
                    commit = 1'b1;
                end
            end
            default: begin
                commit = 1'b0;
            end
        endcase
        commit = commit & RESET_N;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            rd_q     <= 1'b0;
            ack_n_q  <= 1'b1;
            err_q    <= 1'b0;
            dout_vld <= 1'b0;
        end else begin
            ack_n_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q <= ADDR;
                        din_q  <= DIN;
                        rd_q   <= MR;
                        cnt    <= WAIT_LOAD;
                        if (MR && MW) begin
                            err_q <= 1'b1;
                        end
                        if (ZERO_WAIT) begin
                            state   <= ST_DONE;
                            ack_n_q <= 1'b0;
                            if (MR) begin
                                dout_vld <= 1'b1;
                            end
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_ONE) begin
                        state   <= ST_DONE;
                        ack_n_q <= 1'b0;
                        cnt     <= '0;
                        if (rd_q) begin
                            dout_vld <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_bus_sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk  (CLK),
        .we   (commit & ~commit_rd),
        .re   (commit & commit_rd),
        .addr (commit_addr),
        .din  (commit_din),
        .dout (sram_q)
    );

    // The array output has no reset; dout_vld masks it to zero until the
    // first read after reset has loaded it.
    assign DOUT      = dout_vld ? sram_q : '0;
    assign BUSY      = RESET_N & req & (state != ST_DONE);
    assign ACK_N     = ack_n_q;
    assign ERR       = err_q;
    assign RSP_STATE = state;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a 2-wait-state instance and a
// zero-wait instance driven side by side from one clock.
module tb_mem_bus_responder;

    logic        clk;
    logic        rst_n;

    logic        mr, mw;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        busy, ack_n, err;
    logic [1:0]  st;

    logic        mr_b, mw_b;
    logic [4:0]  addr_b;
    logic [31:0] din_b;
    logic [31:0] dout_b;
    logic        busy_b, ack_n_b, err_b;
    logic [1:0]  st_b;

    int checks = 0;
    int errors = 0;

    mem_bus_responder #(
        .ADDR_W      (5),
        .DATA_W      (32),
        .WAIT_CYCLES (2)
    ) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .MR        (mr),
        .MW        (mw),
        .ADDR      (addr),
        .DIN       (din),
        .DOUT      (dout),
        .BUSY      (busy),
        .ACK_N     (ack_n),
        .ERR       (err),
        .RSP_STATE (st)
    );

    mem_bus_responder #(
        .ADDR_W      (5),
        .DATA_W      (32),
        .WAIT_CYCLES (0)
    ) dut_b (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .MR        (mr_b),
        .MW        (mw_b),
        .ADDR      (addr_b),
        .DIN       (din_b),
        .DOUT      (dout_b),
        .BUSY      (busy_b),
        .ACK_N     (ack_n_b),
        .ERR       (err_b),
        .RSP_STATE (st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full handshake on the 2-wait instance; ADDR/DIN are scrambled after
    // acceptance so a responder that re-samples them corrupts the access.
    task automatic a_access(input logic rd, input logic wr, input logic [4:0] a, input logic [31:0] d);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        @(posedge clk); #1;
        mr = rd; mw = wr; addr = a; din = d;
        while (!done && n < 20) begin
            @(negedge clk);
            if (busy === 1'b0 && ack_n === 1'b0) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                addr = a ^ 5'h1F;
                din  = ~d;
                n++;
            end
        end
        check("access_complete", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
        mr = 1'b0; mw = 1'b0;
    endtask

    initial begin
        mr = 0; mw = 0; addr = '0; din = '0;
        mr_b = 0; mw_b = 0; addr_b = '0; din_b = '0;
        rst_n = 1'b0;
        #1 mr = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ack_n", {31'b0, ack_n}, 32'd1);
        check("rst_dout", dout, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_state", {30'b0, st}, 32'd0);
        @(posedge clk); #1;
        mr = 1'b0;
        rst_n = 1'b1;

        // Zero-wait instance: write mem[1], mem[6]
        @(posedge clk); #1;
        mw_b = 1'b1; addr_b = 5'd1; din_b = 32'hCAFEF00D;
        @(negedge clk);
        check("b_wr_c0_busy", {31'b0, busy_b}, 32'd1);
        check("b_wr_c0_ack", {31'b0, ack_n_b}, 32'd1);
        @(negedge clk);
        check("b_wr_c1_ack", {31'b0, ack_n_b}, 32'd0);
        check("b_wr_c1_busy", {31'b0, busy_b}, 32'd0);
        check("b_wr_dout", dout_b, 32'd0);
        @(posedge clk); #1;
        mw_b = 1'b0;
        @(posedge clk); #1;
        mw_b = 1'b1; addr_b = 5'd6; din_b = 32'h66666666;
        @(negedge clk);
        @(negedge clk);
        check("b_wr6_ack", {31'b0, ack_n_b}, 32'd0);
        @(posedge clk); #1;
        mw_b = 1'b0;

        // Zero-wait back-to-back reads, one IDLE cycle between completions
        @(posedge clk); #1;
        mr_b = 1'b1; addr_b = 5'd1;
        @(negedge clk);
        check("b_rd_c0_busy", {31'b0, busy_b}, 32'd1);
        check("b_rd_c0_state", {30'b0, st_b}, 32'd0);
        @(negedge clk);
        check("b_rd_c1_ack", {31'b0, ack_n_b}, 32'd0);
        check("b_rd_c1_dout", dout_b, 32'hCAFEF00D);
        check("b_rd_c1_state", {30'b0, st_b}, 32'd2);
        @(posedge clk); #1;
        addr_b = 5'd6;
        @(negedge clk);
        check("b_rd_c2_state", {30'b0, st_b}, 32'd0);
        check("b_rd_c2_busy", {31'b0, busy_b}, 32'd1);
        check("b_rd_c2_ack", {31'b0, ack_n_b}, 32'd1);
        @(negedge clk);
        check("b_rd_c3_ack", {31'b0, ack_n_b}, 32'd0);
        check("b_rd_c3_dout", dout_b, 32'h66666666);
        @(posedge clk); #1;
        mr_b = 1'b0;
        @(negedge clk);
        check("b_rd_c4_ack", {31'b0, ack_n_b}, 32'd1);
        check("b_rd_c4_dout", dout_b, 32'h66666666);
        check("b_err", {31'b0, err_b}, 32'd0);

        // 2-wait read, cycle by cycle
        a_access(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        @(posedge clk); #1;
        mr = 1'b1; addr = 5'd5;
        @(negedge clk);
        check("rd5_c0_busy", {31'b0, busy}, 32'd1);
        check("rd5_c0_state", {30'b0, st}, 32'd0);
        @(posedge clk); #1;
        addr = 5'd10;
        @(negedge clk);
        check("rd5_c1_busy", {31'b0, busy}, 32'd1);
        check("rd5_c1_state", {30'b0, st}, 32'd1);
        check("rd5_c1_ack", {31'b0, ack_n}, 32'd1);
        @(negedge clk);
        check("rd5_c2_busy", {31'b0, busy}, 32'd1);
        check("rd5_c2_ack", {31'b0, ack_n}, 32'd1);
        @(negedge clk);
        check("rd5_c3_busy", {31'b0, busy}, 32'd0);
        check("rd5_c3_ack", {31'b0, ack_n}, 32'd0);
        check("rd5_c3_dout", dout, 32'hDEADBEEF);
        check("rd5_c3_state", {30'b0, st}, 32'd2);
        @(posedge clk); #1;
        mr = 1'b0;
        @(negedge clk);
        check("rd5_c4_state", {30'b0, st}, 32'd0);
        check("rd5_c4_ack", {31'b0, ack_n}, 32'd1);
        check("rd5_c4_dout", dout, 32'hDEADBEEF);

        // Write then read back
        a_access(1'b0, 1'b1, 5'd7, 32'h12345678);
        check("wr7_dout_kept", dout, 32'hDEADBEEF);
        a_access(1'b1, 1'b0, 5'd7, 32'h0);
        check("rd7_dout", dout, 32'h12345678);

        // Abort: write dropped in first WAIT cycle
        a_access(1'b0, 1'b1, 5'd3, 32'h33333333);
        @(posedge clk); #1;
        mw = 1'b1; addr = 5'd3; din = 32'hAAAA0000;
        @(negedge clk);
        check("abt_c0_busy", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        mw = 1'b0;
        @(negedge clk);
        check("abt_c1_ack", {31'b0, ack_n}, 32'd1);
        check("abt_c1_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("abt_c2_state", {30'b0, st}, 32'd0);
        check("abt_c2_ack", {31'b0, ack_n}, 32'd1);
        @(negedge clk);
        check("abt_c3_ack", {31'b0, ack_n}, 32'd1);
        check("abt_dout_kept", dout, 32'h12345678);
        a_access(1'b1, 1'b0, 5'd3, 32'h0);
        check("abt_rd3", dout, 32'h33333333);

        // Protocol error: MR and MW together behave as a read
        a_access(1'b0, 1'b1, 5'd2, 32'h22222222);
        check("pre_err", {31'b0, err}, 32'd0);
        a_access(1'b1, 1'b1, 5'd2, 32'h00000BAD);
        check("perr_dout", dout, 32'h22222222);
        check("perr_err", {31'b0, err}, 32'd1);
        a_access(1'b1, 1'b0, 5'd2, 32'h0);
        check("perr_rd2", dout, 32'h22222222);
        check("perr_err_sticky", {31'b0, err}, 32'd1);
        a_access(1'b0, 1'b1, 5'd4, 32'h44444444);
        a_access(1'b1, 1'b0, 5'd7, 32'h0);
        check("pre_rst_dout", dout, 32'h12345678);
        check("pre_rst_err", {31'b0, err}, 32'd1);

        // Reset asserted mid-WAIT of a write
        @(posedge clk); #1;
        mw = 1'b1; addr = 5'd4; din = 32'h99999999;
        @(posedge clk); #1;
        check("mid_pre_state", {30'b0, st}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", {31'b0, busy}, 32'd0);
        check("mid_ack", {31'b0, ack_n}, 32'd1);
        check("mid_dout", dout, 32'd0);
        check("mid_state", {30'b0, st}, 32'd0);
        check("mid_err", {31'b0, err}, 32'd0);
        @(posedge clk); #1;
        mw = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_access(1'b1, 1'b0, 5'd4, 32'h0);
        check("mid_rd4", dout, 32'h44444444);
        check("post_err", {31'b0, err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
